// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: the per-edge action
// encoding and the load clamp helper. Imported by counter_updown_n.
package counter_pkg;

  // One action is chosen per clock edge; clear outranks load outranks enable.
  typedef enum logic [2:0] {
    ACT_IDLE  = 3'd0,
    ACT_CLEAR = 3'd1,
    ACT_LOAD  = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4
  } action_e;

  // Saturate a requested value at the counter's highest legal count, so a
  // load can never place the counter outside 0..max_val.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

  // Resolve the control inputs to the single action that takes effect.
  function automatic action_e decode_action(input logic clear,
                                            input logic load,
                                            input logic enable,
                                            input logic up);
    action_e act;
    if (clear)       act = ACT_CLEAR;
    else if (load)   act = ACT_LOAD;
    else if (enable) act = up ? ACT_UP : ACT_DOWN;
    else             act = ACT_IDLE;
    return act;
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational single-step of a modulo-(MAX_VAL+1) counter in either
// direction. at_limit flags that the step wraps around the modulus; the top
// level uses it both for the terminal-count output and the wrap/overflow set.
module counter_step #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_val,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Next value: wrap at the limit, otherwise step by one; the increment is
  // never taken at MAX_VAL, so no value beyond the modulus is ever formed.
  always_comb begin
    at_limit = up ? (count == MAX_W) : (count == '0);
    next_val = count;
    if (at_limit)  next_val = up ? '0 : MAX_W;
    else if (up)   next_val = count + WIDTH'(1);
    else           next_val = count - WIDTH'(1);
  end

endmodule

// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with clear, clamped parallel load, terminal
// count for cascading, registered wrap pulse and sticky overflow flag.
// Optional macro COUNTER_UPDOWN_SNAPSHOT_EN adds a capture input and a
// snapshot register holding the pre-edge count.
module counter_updown_n
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] MAX_VAL   = 32'((64'd1 << WIDTH) - 64'd1),
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             overflow
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
  ,
  input  logic             capture,
  output logic [WIDTH-1:0] snapshot
`endif
);

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] step_next;
  logic             at_limit;
  action_e          act;

  counter_step #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .count    (count_q),
    .up       (up),
    .next_val (step_next),
    .at_limit (at_limit)
  );

  // Pick the one action that applies on the coming edge.
  always_comb act = decode_action(clear, load, enable, up);

  // Next-state for count, wrap and overflow; wrap defaults low so it is a
  // single-cycle pulse, overflow defaults to holding.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    overflow_d = overflow_q;
    case (act)
      ACT_CLEAR: begin
        count_d    = RESET_W;
        overflow_d = 1'b0;
      end
      ACT_LOAD: begin
        count_d    = WIDTH'(clamp_to_max(32'(load_val), MAX_VAL));
        overflow_d = 1'b0;
      end
      ACT_UP, ACT_DOWN: begin
        count_d    = step_next;
        wrap_d     = at_limit;
        overflow_d = overflow_q | at_limit;
      end
      default: ;
    endcase
  end

  // State registers, asynchronously returned to their reset values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= RESET_W;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
    end
  end

  // Terminal count is unregistered so a chained stage steps on the same edge.
  always_comb tc = enable & at_limit;

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign overflow = overflow_q;

`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
  logic [WIDTH-1:0] snapshot_q, snapshot_d;

  // Capture the count as it stands before this edge's update.
  always_comb snapshot_d = capture ? count_q : snapshot_q;

  // Snapshot register; only reset touches it, clear and load do not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) snapshot_q <= '0;
    else       snapshot_q <= snapshot_d;
  end

  assign snapshot = snapshot_q;
`else
  // No capture port and no snapshot register in this build.
`endif

endmodule

// File: tb/tb_counter_updown_n.sv
// Bench for counter_updown_n: a WIDTH=4/MAX_VAL=9 instance, a WIDTH=1 toggle
// instance sharing its controls, and two chained 4-bit instances.
module tb_counter_updown_n;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chain_rst = 1'b1;
  always #5 clock = ~clock;

  logic       enable = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       capture = 1'b0;

  logic [3:0] count;
  logic       tc, wrap, overflow;
  logic [0:0] t_count;
  logic       t_tc, t_wrap, t_ovf;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf;
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
  logic [3:0] snapshot;
  logic [0:0] t_snap;
  logic [3:0] lo_snap, hi_snap;
`endif

  counter_updown_n #(.WIDTH(4), .MAX_VAL(32'd9), .RESET_VAL(32'd0)) dut (
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
    .capture(capture), .snapshot(snapshot),
`endif
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .wrap(wrap),
    .overflow(overflow));

  counter_updown_n #(.WIDTH(1), .MAX_VAL(32'd1), .RESET_VAL(32'd1)) u_t1 (
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
    .capture(1'b0), .snapshot(t_snap),
`endif
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_val(load_val[0:0]), .count(t_count), .tc(t_tc),
    .wrap(t_wrap), .overflow(t_ovf));

  counter_updown_n #(.WIDTH(4), .MAX_VAL(32'd15)) u_lo (
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
    .capture(1'b0), .snapshot(lo_snap),
`endif
    .clock(clock), .reset(chain_rst), .enable(1'b1), .up(1'b1), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .count(lo_count), .tc(lo_tc),
    .wrap(lo_wrap), .overflow(lo_ovf));

  counter_updown_n #(.WIDTH(4), .MAX_VAL(32'd15)) u_hi (
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
    .capture(1'b0), .snapshot(hi_snap),
`endif
    .clock(clock), .reset(chain_rst), .enable(lo_tc), .up(1'b1), .clear(1'b0),
    .load(1'b0), .load_val(4'd0), .count(hi_count), .tc(hi_tc),
    .wrap(hi_wrap), .overflow(hi_ovf));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned cnt;
    bit          wrap;
    bit          ovf;
  } mstate_t;

  function automatic mstate_t model_next(input mstate_t s, input int unsigned maxv,
                                         input int unsigned rv, input bit en, input bit u,
                                         input bit clr, input bit ld, input int unsigned lv);
    mstate_t n;
    n = s;
    n.wrap = 1'b0;
    if (clr) begin
      n.cnt = rv; n.ovf = 1'b0;
    end else if (ld) begin
      n.cnt = (lv > maxv) ? maxv : lv; n.ovf = 1'b0;
    end else if (en) begin
      if (u) begin
        n.wrap = (s.cnt == maxv); n.cnt = (s.cnt + 1) % (maxv + 1);
      end else begin
        n.wrap = (s.cnt == 0);    n.cnt = (s.cnt + maxv) % (maxv + 1);
      end
      n.ovf = s.ovf | n.wrap;
    end
    return n;
  endfunction

  function automatic bit model_tc(input mstate_t s, input int unsigned maxv,
                                  input bit en, input bit u);
    return en && (u ? (s.cnt == maxv) : (s.cnt == 0));
  endfunction

  mstate_t     m_main, m_t1;
  int unsigned m_snap;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_main = '{0, 1'b0, 1'b0};
      m_t1   = '{1, 1'b0, 1'b0};
      m_snap = 0;
    end else begin
      if (capture) m_snap = m_main.cnt;
      m_main = model_next(m_main, 9, 0, enable, up, clear, load, load_val);
      m_t1   = model_next(m_t1, 1, 1, enable, up, clear, load, load_val[0]);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clock) begin
    #1;
    if (!done) begin
      check("count", count, m_main.cnt);
      check("tc", tc, model_tc(m_main, 9, enable, up));
      check("wrap", wrap, m_main.wrap);
      check("overflow", overflow, m_main.ovf);
      check("t1_count", t_count, m_t1.cnt);
      check("t1_tc", t_tc, model_tc(m_t1, 1, enable, up));
      check("t1_wrap", t_wrap, m_t1.wrap);
      check("t1_overflow", t_ovf, m_t1.ovf);
`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
      check("snapshot", snapshot, m_snap);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit en, input bit u, input bit clr, input bit ld,
                       input logic [3:0] lv, input bit cap = 1'b0);
    @(negedge clock);
    enable = en; up = u; clear = clr; load = ld; load_val = lv; capture = cap;
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp1[12];
    int exp2[7];
    exp1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp2 = '{4, 3, 2, 1, 0, 9, 8};

    repeat (2) @(negedge clock);
    check("rst_count", count, 0);
    check("rst_wrap", wrap, 0);
    check("rst_overflow", overflow, 0);
    check("rst_t1_count", t_count, 1);
    reset = 1'b0;

    // Count up from reset across the modulus.
    for (int k = 0; k < 12; k++) begin
      cycle(1, 1, 0, 0, 4'd0);
      check("up_count", count, exp1[k]);
      check("up_tc", tc, (k == 8));
      check("up_wrap", wrap, (k == 9));
      check("up_overflow", overflow, (k >= 9));
    end

    // Load 5 (load beats enable), then count down through zero.
    cycle(1, 1, 0, 1, 4'd5);
    check("load5_count", count, 5);
    check("load5_overflow", overflow, 0);
    for (int k = 0; k < 7; k++) begin
      cycle(1, 0, 0, 0, 4'd0);
      check("down_count", count, exp2[k]);
      check("down_tc", tc, (k == 4));
      check("down_wrap", wrap, (k == 5));
    end

    // Clamp, idle, down-wrap, clear-over-load, direction change.
    cycle(0, 1, 0, 1, 4'd14);
    check("clamp_count", count, 9);
    check("clamp_overflow", overflow, 0);
    cycle(1, 1, 0, 0, 4'd0);
    check("wrap_up_count", count, 0);
    check("wrap_up_pulse", wrap, 1);
    cycle(0, 1, 0, 0, 4'd0);
    check("idle_count", count, 0);
    check("idle_wrap", wrap, 0);
    check("idle_overflow", overflow, 1);
    cycle(1, 0, 0, 0, 4'd0);
    check("wrap_dn_count", count, 9);
    cycle(1, 1, 1, 1, 4'd3);
    check("clr_count", count, 0);
    check("clr_overflow", overflow, 0);
    check("clr_t1_count", t_count, 1);
    cycle(0, 1, 0, 1, 4'd6);
    cycle(1, 0, 0, 0, 4'd0);
    check("dir_dn_count", count, 5);
    cycle(1, 1, 0, 0, 4'd0);
    check("dir_up_count", count, 6);

    // Reach 7 with overflow set, then reset between edges.
    cycle(0, 1, 0, 1, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    check("pre_arst_count", count, 7);
    check("pre_arst_overflow", overflow, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_wrap", wrap, 0);
    check("arst_overflow", overflow, 0);
    check("arst_t1_count", t_count, 1);
    @(negedge clock);
    reset = 1'b0;
    cycle(0, 1, 0, 0, 4'd0);

`ifdef COUNTER_UPDOWN_SNAPSHOT_EN
    cycle(0, 1, 0, 1, 4'd3);
    cycle(1, 1, 0, 0, 4'd0, 1'b1);
    check("snap_count", count, 4);
    check("snap_value", snapshot, 3);
    cycle(1, 1, 1, 0, 4'd0, 1'b0);
    check("snap_after_clear", snapshot, 3);
`endif

    // Two chained 4-bit stages behave as one 8-bit counter.
    @(negedge clock);
    chain_rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock);
      #1;
      check("chain_value", {hi_count, lo_count}, k % 256);
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_updown_n.md
Name: counter_updown_n

Overview:
- Parametrised synchronous up/down counter. Next generation of the team's fixed 8-bit toggle-chain counter.
- Adds configurable width and modulus, direction control, parallel load, synchronous clear, terminal-count output for cascading, a registered wrap pulse and a sticky overflow flag.
- Used as the general counting primitive in timers, address generators and event counters. Wider counters are built by chaining the terminal-count output of one instance into the enable of the next.

Parameters:
- WIDTH, 8, counter width in bits; legal range 1..32.
- MAX_VAL, (1<<WIDTH)-1, highest count value. Count range is 0..MAX_VAL. Must satisfy 0 < MAX_VAL <= 2^WIDTH-1.
- RESET_VAL, 0, value loaded by reset and by clear. Must satisfy RESET_VAL <= MAX_VAL.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational).
- wrap  out  1  registered one-cycle pulse after a wrap.
- overflow  out  1  sticky wrap flag.

Behaviour:
- Reset (async, active-high): count=RESET_VAL, wrap=0, overflow=0. Outputs hold while reset is high. First update happens on the first rising edge after reset deasserts.
- Per-edge priority: clear > load > enable. Only the highest-priority active action takes effect.
- clear: count<=RESET_VAL, overflow<=0, wrap<=0.
- load: count<=min(load_val, MAX_VAL) (out-of-range values clamp to MAX_VAL), overflow<=0, wrap<=0.
- enable with up=1:
  - count==MAX_VAL: count<=0, wrap<=1, overflow<=1.
  - otherwise: count<=count+1.
- enable with up=0:
  - count==0: count<=MAX_VAL, wrap<=1, overflow<=1.
  - otherwise: count<=count-1.
- Idle (no action active): count holds, wrap<=0.
- tc = enable & ((up & count==MAX_VAL) | (~up & count==0)).
  - Purely combinational, with no register stage, so a chained instance steps on the same edge as this instance wraps.
- Latency:
  - count updates one edge after the qualifying inputs.
  - wrap is high for exactly the one cycle following the wrapping edge.
- Direction may change on any cycle. The new direction applies on that edge with no penalty.
- All arithmetic is WIDTH bits. No intermediate value may exceed MAX_VAL (no raw overflow past the modulus).
- Reset asserted mid-count: immediate return to reset values, independent of clock.
- WIDTH=1, MAX_VAL=1: the block behaves as a toggle flip-flop with tc=enable&(up?count:~count).

Optional Feature:
- Macro: COUNTER_UPDOWN_SNAPSHOT_EN.
- When defined, adds input capture (1 bit) and output snapshot (WIDTH bits).
  - On an edge with capture=1, snapshot<=count as it stands before that edge's update.
  - snapshot resets to 0 on reset and is unaffected by clear and load.
- When undefined, neither port exists and there is no capture register.

Decomposition:
- Shared package counter_pkg holds:
  - the action encoding constants ACT_IDLE, ACT_CLEAR, ACT_LOAD, ACT_UP, ACT_DOWN;
  - the function clamp_to_max(value, max).
- One natural sub-module, counter_step (combinational).
  - Inputs: count, up, MAX_VAL.
  - Outputs: next value and at_limit.
  - Top level uses at_limit for both tc and the wrap/overflow set.

Test Plan:
- WIDTH=4, MAX_VAL=9, up=1, enable=1 from reset, 12 cycles -> count 0..9,0,1; tc high only while count=9; wrap high in the cycle count=0 appears; overflow=1 thereafter.
- Same config, load_val=5 then up=0 for 7 cycles -> 5,4,3,2,1,0,9,8; tc high at count=0; wrap pulse once.
- Same config, load=1 with load_val=14 -> count=9 (clamped), overflow cleared. Then clear and load together -> count=RESET_VAL.
- Two WIDTH=4, MAX_VAL=15 instances chained (tc0 -> enable1), 300 cycles -> {count1,count0} equals cycle count mod 256, matching a single 8-bit counter.
- Reset pulsed asynchronously mid-count at count=7 between clock edges -> count=0, wrap=0, overflow=0 immediately, with no clock edge needed.
- With COUNTER_UPDOWN_SNAPSHOT_EN: capture=1 while count=3 and enable=1 -> snapshot=3 on that edge while count becomes 4.
